// File: rtl/fpu_pkg.sv
// fpu_pkg
//   Shared definitions for the FP pipeline control slice: FP op encodings,
//   div/sqrt sequencer state type, legal DIV_CYCLES bounds and small
//   op-classification helpers used by the pipeline controller.
package fpu_pkg;

    localparam logic [2:0] FC_ADD  = 3'b000;
    localparam logic [2:0] FC_SUB  = 3'b001;
    localparam logic [2:0] FC_MUL  = 3'b010;
    localparam logic [2:0] FC_DIV  = 3'b011;
    localparam logic [2:0] FC_SQRT = 3'b100;

    localparam int DIV_CYCLES_MIN = 2;
    localparam int DIV_CYCLES_MAX = 31;

    typedef enum logic {
        DS_IDLE = 1'b0,
        DS_BUSY = 1'b1
    } div_state_e;

    // Codes 101..111 are not real ops; they flow down the pipe but never write.
    function automatic logic fc_is_defined(input logic [2:0] fc);
        return (fc <= FC_SQRT);
    endfunction

    function automatic logic fc_is_div_sqrt(input logic [2:0] fc);
        return (fc == FC_DIV) || (fc == FC_SQRT);
    endfunction

endpackage

// File: rtl/fpu_pipe_ctrl_if.sv
// fpu_pipe_ctrl_if
//   Bundle between the integer unit / FP datapath (master) and the FP
//   pipeline controller (slave).
//   master -> slave : fs, ft, fd, fc, wf, fasmds, fwdfa/fwdfb, fwdla/fwdlb,
//                     mmo, wmo, wrn, wwfpr, stall_lw/fp/lwc1/swc1, fres
//   slave -> master : fa, fb, e1c, div_start, e1n/e2n/e3n, e1w/e2w/e3w,
//                     stall_div_sqrt, st, dfb, e3d
interface fpu_pipe_ctrl_if;
    logic [4:0]  fs, ft, fd;
    logic [2:0]  fc;
    logic        wf, fasmds;
    logic        fwdfa, fwdfb, fwdla, fwdlb;
    logic [31:0] mmo, wmo;
    logic [4:0]  wrn;
    logic        wwfpr;
    logic        stall_lw, stall_fp, stall_lwc1, stall_swc1;
    logic [31:0] fres;

    logic [31:0] fa, fb;
    logic [2:0]  e1c;
    logic        div_start;
    logic [4:0]  e1n, e2n, e3n;
    logic        e1w, e2w, e3w;
    logic        stall_div_sqrt, st;
    logic [31:0] dfb, e3d;

    modport master (
        output fs, ft, fd, fc, wf, fasmds, fwdfa, fwdfb, fwdla, fwdlb,
               mmo, wmo, wrn, wwfpr, stall_lw, stall_fp, stall_lwc1, stall_swc1, fres,
        input  fa, fb, e1c, div_start, e1n, e2n, e3n, e1w, e2w, e3w,
               stall_div_sqrt, st, dfb, e3d
    );

    modport slave (
        input  fs, ft, fd, fc, wf, fasmds, fwdfa, fwdfb, fwdla, fwdlb,
               mmo, wmo, wrn, wwfpr, stall_lw, stall_fp, stall_lwc1, stall_swc1, fres,
        output fa, fb, e1c, div_start, e1n, e2n, e3n, e1w, e2w, e3w,
               stall_div_sqrt, st, dfb, e3d
    );
endinterface

// File: rtl/fpu_regfile.sv
// fpu_regfile
//   32 x 32-bit FP register file, not reset.
//   Write ports (clk edge): e3_* (E3 result) and wb_* (lwc1 in WB); the E3
//   port wins on an index collision.
//   Read ports ra_a/ra_b/ra_c -> rd_a/rd_b/rd_c are write-through with the
//   same priority, so a same-cycle reader sees the value about to land.
module fpu_regfile (
    input  logic        clk,
    input  logic        e3_we,
    input  logic [4:0]  e3_addr,
    input  logic [31:0] e3_data,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic [4:0]  ra_a,
    input  logic [4:0]  ra_b,
    input  logic [4:0]  ra_c,
    output logic [31:0] rd_a,
    output logic [31:0] rd_b,
    output logic [31:0] rd_c
);

    logic [31:0] mem [32];

    // E3 write is issued last so it overrides the WB write to the same index.
    always_ff @(posedge clk) begin
        if (wb_we) mem[wb_addr] <= wb_data;
        if (e3_we) mem[e3_addr] <= e3_data;
    end

    function automatic logic [31:0] read_port(input logic [4:0] ra, input logic [31:0] stored);
        if (e3_we && (e3_addr == ra))      return e3_data;
        else if (wb_we && (wb_addr == ra)) return wb_data;
        else                               return stored;
    endfunction

    always_comb begin
        rd_a = read_port(ra_a, mem[ra_a]);
        rd_b = read_port(ra_b, mem[ra_b]);
        rd_c = read_port(ra_c, mem[ra_c]);
    end

endmodule

// File: rtl/fpu_pipe_ctrl.sv
// fpu_pipe_ctrl
//   FP pipeline control shell downstream of the integer unit. Tracks
//   destination tags through E1/E2/E3, captures the E3 result, selects the
//   datapath operands (forwarding or register file) and raises stalls.
//   Ports: clk, rst_n (async active-low), bus (fpu_pipe_ctrl_if.slave).
//   Parameter DIV_CYCLES: E1 occupancy of a div/sqrt op (2..31).
//   Build option FPU_DIV_SQRT_EN: when defined, a div/sqrt sequencer holds
//   E1 for DIV_CYCLES cycles; when undefined, div/sqrt flow through as
//   non-writing 3-cycle NOPs and div_start/stall_div_sqrt stay 0.
module fpu_pipe_ctrl
    import fpu_pkg::*;
#(
    parameter int DIV_CYCLES = 8
) (
    input logic             clk,
    input logic             rst_n,
    fpu_pipe_ctrl_if.slave  bus
);

    localparam int DIV_CYC = (DIV_CYCLES < DIV_CYCLES_MIN) ? DIV_CYCLES_MIN :
                             (DIV_CYCLES > DIV_CYCLES_MAX) ? DIV_CYCLES_MAX : DIV_CYCLES;
    localparam logic [4:0] DIV_LOAD = 5'(DIV_CYC - 1);

    logic        st, issue, issue_writes;
    logic        stall_div_sqrt, div_start;
    logic [4:0]  e1n_q, e2n_q, e3n_q, e1n_d, e2n_d, e3n_d;
    logic        e1w_q, e2w_q, e3w_q, e1w_d, e2w_d, e3w_d;
    logic [2:0]  e1c_q, e1c_d;
    logic [31:0] e3d_q, e3d_d;
    logic [31:0] rd_a, rd_b, rd_c;

    assign st    = bus.stall_lw | bus.stall_fp | bus.stall_lwc1 | bus.stall_swc1 | stall_div_sqrt;
    assign issue = bus.fasmds & ~st;

`ifdef FPU_DIV_SQRT_EN
    assign issue_writes = bus.wf & fc_is_defined(bus.fc);

    div_state_e state_q;
    logic [4:0] cnt_q;
    logic       stall_q, start_q;
    logic       issue_div;

    assign issue_div = issue & fc_is_div_sqrt(bus.fc);

    // Counter loads DIV_CYCLES-1 on issue; stall drops when it reaches 0, and
    // that last cycle may accept a fresh div/sqrt since st is low again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DS_IDLE;
            cnt_q   <= 5'd0;
            stall_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if ((state_q == DS_BUSY) && (cnt_q != 5'd0)) begin
                cnt_q   <= cnt_q - 5'd1;
                stall_q <= (cnt_q != 5'd1);
            end else if (issue_div) begin
                state_q <= DS_BUSY;
                cnt_q   <= DIV_LOAD;
                stall_q <= 1'b1;
                start_q <= 1'b1;
            end else begin
                state_q <= DS_IDLE;
                stall_q <= 1'b0;
            end
        end
    end

    assign stall_div_sqrt = stall_q;
    assign div_start      = start_q;
`else
    // Without the sequencer, div/sqrt must not claim a write.
    assign issue_writes   = bus.wf & fc_is_defined(bus.fc) & ~fc_is_div_sqrt(bus.fc);
    assign stall_div_sqrt = 1'b0;
    assign div_start      = 1'b0;
`endif

    // E1 holds during div/sqrt, otherwise takes the issued op or a bubble;
    // E2 sees a bubble while E1 is held; E3 and the result always advance.
    always_comb begin
        e1n_d = 5'd0;
        e1w_d = 1'b0;
        e1c_d = 3'd0;
        if (stall_div_sqrt) begin
            e1n_d = e1n_q;
            e1w_d = e1w_q;
            e1c_d = e1c_q;
        end else if (issue) begin
            e1n_d = bus.fd;
            e1w_d = issue_writes;
            e1c_d = bus.fc;
        end
        e2n_d = stall_div_sqrt ? 5'd0 : e1n_q;
        e2w_d = stall_div_sqrt ? 1'b0 : e1w_q;
        e3n_d = e2n_q;
        e3w_d = e2w_q;
        e3d_d = bus.fres;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e1n_q <= 5'd0;  e2n_q <= 5'd0;  e3n_q <= 5'd0;
            e1w_q <= 1'b0;  e2w_q <= 1'b0;  e3w_q <= 1'b0;
            e1c_q <= 3'd0;
            e3d_q <= 32'd0;
        end else begin
            e1n_q <= e1n_d;  e2n_q <= e2n_d;  e3n_q <= e3n_d;
            e1w_q <= e1w_d;  e2w_q <= e2w_d;  e3w_q <= e3w_d;
            e1c_q <= e1c_d;
            e3d_q <= e3d_d;
        end
    end

    fpu_regfile u_regfile (
        .clk     (clk),
        .e3_we   (e3w_q),
        .e3_addr (e3n_q),
        .e3_data (e3d_q),
        .wb_we   (bus.wwfpr),
        .wb_addr (bus.wrn),
        .wb_data (bus.wmo),
        .ra_a    (bus.fs),
        .ra_b    (bus.ft),
        .ra_c    (bus.ft),
        .rd_a    (rd_a),
        .rd_b    (rd_b),
        .rd_c    (rd_c)
    );

    assign bus.fa  = bus.fwdfa ? e3d_q : (bus.fwdla ? bus.mmo : rd_a);
    assign bus.fb  = bus.fwdfb ? e3d_q : (bus.fwdlb ? bus.mmo : rd_b);
    assign bus.dfb = bus.fwdfb ? e3d_q : (bus.fwdlb ? bus.mmo : rd_c);

    assign bus.st             = st;
    assign bus.stall_div_sqrt = stall_div_sqrt;
    assign bus.div_start      = div_start;
    assign bus.e1n = e1n_q;  assign bus.e2n = e2n_q;  assign bus.e3n = e3n_q;
    assign bus.e1w = e1w_q;  assign bus.e2w = e2w_q;  assign bus.e3w = e3w_q;
    assign bus.e1c = e1c_q;
    assign bus.e3d = e3d_q;

endmodule

// File: doc/fpu_pipe_ctrl.md
# fpu_pipe_ctrl

Floating-point pipeline control and register-file shell that sits directly downstream of the integer unit. It consumes the decoded FP fields and forwarding selects, holds the 32×32 FP register file, and drives the two operands into the external FP arithmetic datapath. It tracks destination tags through E1/E2/E3 and produces the E3 result, store data and stall signals back to the integer unit.

## Interface
Parameters:
- DIV_CYCLES, 8, total E1 occupancy of a div/sqrt op; legal range 2..31.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- fs, ft, fd  in  5  FP source/source/destination register numbers (ID)
- fc  in  3  FP op: 000 add, 001 sub, 010 mul, 011 div, 100 sqrt
- wf  in  1  ID op writes an FPR
- fasmds  in  1  ID op is an FP arithmetic op
- fwdfa, fwdfb  in  1  forward e3d to operand a/b
- fwdla, fwdlb  in  1  forward mmo (lwc1 in MEM) to operand a/b
- mmo, wmo  in  32  MEM load data / WB load data
- wrn  in  5  WB destination
- wwfpr  in  1  WB writes FPR (lwc1)
- stall_lw, stall_fp, stall_lwc1, stall_swc1  in  1  IU stall terms
- fres  in  32  datapath result for the E2 op
- fa, fb  out  32  operands to the datapath (ID-stage, combinational)
- e1c  out  3  op code in E1
- div_start  out  1  one-cycle start pulse to the div/sqrt datapath
- e1n, e2n, e3n  out  5  destination tags in E1/E2/E3
- e1w, e2w, e3w  out  1  write-enable tags in E1/E2/E3
- stall_div_sqrt  out  1  div/sqrt occupies E1
- st  out  1  global stall to the IU
- dfb  out  32  forwarded ft value for swc1 store data
- e3d  out  32  E3 result

## Operation
- st = stall_lw | stall_fp | stall_lwc1 | stall_swc1 | stall_div_sqrt.
- Issue: when fasmds & ~st, E1 is loaded with {fd, wf, fc}. Otherwise a bubble is loaded (e1w=0), except during stall_div_sqrt, when E1 holds its contents.
- Advance: each cycle E2←E1 and E3←E2. During stall_div_sqrt, E2 receives a bubble (e2w=0) and E3←E2 continues. e3d←fres whenever E2 advances into E3.
- Operand select, for a (b is symmetric with ft, fwdfb, fwdlb): fwdfa ? e3d : fwdla ? mmo : rf[fs]. dfb uses the same selection as fb.
- Register file: 32×32 with two write ports at the clock edge.
  - Port 1: e3w writes e3d to rf[e3n].
  - Port 2: wwfpr writes wmo to rf[wrn].
  - Same-index collision: the e3 write wins.
  - Reads are write-through: a read of an index being written in the current cycle returns the new data, with the same priority.
- Div/sqrt FSM, states IDLE and BUSY:
  - IDLE→BUSY on issue of fc∈{011,100}. div_start pulses in the first E1 cycle and the counter loads DIV_CYCLES-1.
  - In BUSY, stall_div_sqrt=1 and the counter decrements each cycle. At count 0 stall_div_sqrt drops and the state returns to IDLE, so E1 is occupied for exactly DIV_CYCLES cycles.
  - A new div/sqrt cannot be issued while BUSY because st is high.
- Undefined fc (101–111) issues with e1w forced to 0.

## Timing
- Reset values: e1n/e2n/e3n=0, e1w/e2w/e3w=0, e1c=0, e3d=0, stall_div_sqrt=0, div_start=0, FSM IDLE, counter 0. The register file is not reset.
- add/sub/mul latency: issue at edge N, tag in E3 after edge N+2, rf written at edge N+3.
- div/sqrt: stall_div_sqrt is high for cycles N+1..N+DIV_CYCLES-1, and the tag reaches E3 DIV_CYCLES+1 edges after issue.
- Reset asserted mid-BUSY clears the FSM and all tags immediately (asynchronous). No write occurs for the aborted op.
- fa, fb, dfb and st are combinational. All other outputs are registered.

## Configuration
- FPU_DIV_SQRT_EN defined: the FSM, counter, div_start and stall_div_sqrt are built as above.
- FPU_DIV_SQRT_EN undefined: no FSM is built, and stall_div_sqrt and div_start are tied to 0. Div/sqrt issue with e1w forced to 0, behaving as a 3-cycle NOP that does not write.

## Structure
- Shared package fpu_pkg holds the fc encodings (FC_ADD…FC_SQRT), the FSM state typedef, and DIV_CYCLES bounds.
- One sub-module, fpu_regfile: 32×32, two write ports with e3 priority, three write-through read ports (fs, ft, ft for dfb).

## Test plan
- Issue add (fd=3, wf=1), fres=0x3F800000 → e3n=3, e3w=1 two edges later; rf[3]=0x3F800000 on the next edge.
- Write rf[5] via wwfpr=1, wrn=5, wmo=0x40000000, while reading fs=5 in the same cycle → fa=0x40000000.
- Simultaneous e3 write and WB write to index 7 (e3d=0x11, wmo=0x22) → rf[7]=0x11.
- Issue div with DIV_CYCLES=8 → div_start pulses once, stall_div_sqrt=1 for 7 cycles, st=1, E1 held, e2w=0; the tag reaches E3 9 edges after issue.
- fwdfa=1 and fwdla=1 with e3d=0xA, mmo=0xB → fa=0xA; fwdfa=0 → fa=0xB.
- rst_n low for 1 cycle during div BUSY → all tags 0, stall_div_sqrt=0, and no rf write for that op.
